axil_cmd_master: RTL and testbench

Synthesisable AXI4-Lite master that replaces hand-written bench write/read tasks with a queued command engine.
- Accepts write/read commands on a valid/ready command port and buffers them in a FIFO of depth CMD_DEPTH.
- Executes commands strictly in order on the amba_axi4_lite_if master side.
- Returns one response per command on a valid/ready response port.
- Used in the bench to drive the adder peripheral (regfile/control/datapath), and reusable as an on-chip register sequencer.

---
 rtl/axil_cmd_pkg.sv | 16 +
 rtl/amba_axi4_lite_if.sv | 31 +++
 rtl/axil_cmd_fifo.sv | 38 +++
 rtl/axil_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_cmd_pkg.sv
// axil_cmd_pkg: shared types for the AXI4-Lite command master
// Contents: FSM state enum, AXI response codes, queued command record.
package axil_cmd_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
  } cmd_t;
endpackage

// File: rtl/amba_axi4_lite_if.sv
// amba_axi4_lite_if: AXI4-Lite signal bundle
// Modports: master drives AW/W/AR VALID+payload and B/R READY; slave is the mirror.
interface amba_axi4_lite_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_cmd_fifo.sv
// axil_cmd_fifo: command FIFO of CMD_DEPTH cmd_t entries
// Ports: ACLK, ARSTn (async active-low), push/din, pop/dout (first-word fall-through), full, empty.
module axil_cmd_fifo
  import axil_cmd_pkg::*;
#(
  parameter int CMD_DEPTH = 4
) (
  input  logic ACLK,
  input  logic ARSTn,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("CMD_DEPTH must be a power of two >= 2");
  end
  cmd_t mem [CMD_DEPTH];
  // Extra MSB on each pointer separates full from empty when the indices match.
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge ACLK or negedge ARSTn)
    if (!ARSTn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + ONE;
      if (pop) rp <= rp + ONE;
    end
  always_ff @(posedge ACLK)
    if (push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: queued AXI4-Lite master, one transaction outstanding, responses returned in order
// Ports: ACLK, ARSTn (async active-low); amba (AXI4-Lite master modport);
//   command port i_cmd_valid/o_cmd_ready + write/addr/data/strb/prot;
//   response port o_rsp_valid/i_rsp_ready + write/data/resp/timeout; o_busy.
// Build option: define AXIL_TIMEOUT_EN to abort a stalled handshake after TIMEOUT_CYC cycles.
module axil_cmd_master
  import axil_cmd_pkg::*;
#(
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                    ACLK,
  input  logic                    ARSTn,
  amba_axi4_lite_if.master        amba,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [31:0]             i_cmd_addr,
  input  logic [31:0]             i_cmd_data,
  input  logic [3:0]              i_cmd_strb,
  input  logic [2:0]              i_cmd_prot,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic                    o_rsp_write,
  output logic [31:0]             o_rsp_data,
  output logic [1:0]              o_rsp_resp,
  output logic                    o_rsp_timeout,
  output logic                    o_busy
);
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 16-bit watchdog");
  end
  state_t      state, state_n;
  cmd_t        cur, cur_n, head;
  logic        aw_v, aw_n, w_v, w_n, b_r, b_n, ar_v, ar_n, r_r, r_n;
  logic        rsp_v, rsp_n;
  logic [31:0] rd, rd_n;
  logic [1:0]  rr, rr_n;
  logic        full, empty, pop;
`ifdef AXIL_TIMEOUT_EN
  logic [15:0] cnt;
  logic        expired, tf;
`endif
  axil_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
    .ACLK (ACLK),
    .ARSTn(ARSTn),
    .push (i_cmd_valid && !full),
    .din  ('{i_cmd_write, i_cmd_addr, i_cmd_data, i_cmd_strb, i_cmd_prot}),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign o_cmd_ready  = !full;
  assign o_busy       = (state != IDLE) || !empty;
  assign o_rsp_valid  = rsp_v;
  assign o_rsp_write  = cur.write;
  assign o_rsp_data   = rd;
  assign o_rsp_resp   = rr;
  // Payload comes from the held command, so it is stable for as long as any VALID is high.
  assign amba.awaddr  = cur.addr;
  assign amba.awprot  = cur.prot;
  assign amba.araddr  = cur.addr;
  assign amba.arprot  = cur.prot;
  assign amba.wdata   = cur.data;
  assign amba.wstrb   = cur.strb;
  assign amba.awvalid = aw_v;
  assign amba.wvalid  = w_v;
  assign amba.bready  = b_r;
  assign amba.arvalid = ar_v;
  assign amba.rready  = r_r;
`ifdef AXIL_TIMEOUT_EN
  assign expired = (state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP}) && cnt >= 16'(TIMEOUT_CYC);
  always_ff @(posedge ACLK or negedge ARSTn)
    if (!ARSTn) begin
      cnt <= '0;
      tf  <= 1'b0;
    end else begin
      cnt <= (state_n != state) ? '0 : cnt + 16'd1;
      tf  <= expired ? 1'b1 : pop ? 1'b0 : tf;
    end
  assign o_rsp_timeout = tf;
`else
  assign o_rsp_timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cur_n   = cur;
    aw_n    = aw_v;
    w_n     = w_v;
    b_n     = b_r;
    ar_n    = ar_v;
    r_n     = r_r;
    rsp_n   = rsp_v;
    rd_n    = rd;
    rr_n    = rr;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty && !rsp_v) begin
        pop     = 1'b1;
        cur_n   = head;
        state_n = head.write ? WR_REQ : RD_REQ;
        aw_n    = head.write;
        w_n     = head.write;
        ar_n    = !head.write;
        rd_n    = '0;
        rr_n    = RESP_OKAY;
      end
      // AW and W retire independently; whichever finishes first drops its VALID alone.
      WR_REQ: begin
        aw_n = aw_v && !amba.awready;
        w_n  = w_v && !amba.wready;
        if (!aw_n && !w_n) begin
          state_n = WR_RESP;
          b_n     = 1'b1;
        end
      end
      WR_RESP: if (amba.bvalid) begin
        rr_n    = amba.bresp;
        b_n     = 1'b0;
        rsp_n   = 1'b1;
        state_n = RSP;
      end
      RD_REQ: if (amba.arready) begin
        ar_n    = 1'b0;
        r_n     = 1'b1;
        state_n = RD_RESP;
      end
      RD_RESP: if (amba.rvalid) begin
        rd_n    = amba.rdata;
        rr_n    = amba.rresp;
        r_n     = 1'b0;
        rsp_n   = 1'b1;
        state_n = RSP;
      end
      RSP: if (i_rsp_ready) begin
        rsp_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef AXIL_TIMEOUT_EN
    if (expired) begin
      aw_n    = 1'b0;
      w_n     = 1'b0;
      b_n     = 1'b0;
      ar_n    = 1'b0;
      r_n     = 1'b0;
      rsp_n   = 1'b1;
      rd_n    = '0;
      rr_n    = RESP_SLVERR;
      state_n = RSP;
    end
`endif
  end
  always_ff @(posedge ACLK or negedge ARSTn)
    if (!ARSTn) begin
      state <= IDLE;
      cur   <= '0;
      aw_v  <= 1'b0;
      w_v   <= 1'b0;
      b_r   <= 1'b0;
      ar_v  <= 1'b0;
      r_r   <= 1'b0;
      rsp_v <= 1'b0;
      rd    <= '0;
      rr    <= RESP_OKAY;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      aw_v  <= aw_n;
      w_v   <= w_n;
      b_r   <= b_n;
      ar_v  <= ar_n;
      r_r   <= r_n;
      rsp_v <= rsp_n;
      rd    <= rd_n;
      rr    <= rr_n;
    end
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed bench for axil_cmd_master against a small adder-style AXI4-Lite slave model
module tb_axil_cmd_master;
  logic        ACLK = 1'b0;
  logic        ARSTn = 1'b0;
  logic        i_cmd_valid = 1'b0, i_cmd_write = 1'b0;
  logic [31:0] i_cmd_addr = '0, i_cmd_data = '0;
  logic [3:0]  i_cmd_strb = '0;
  logic [2:0]  i_cmd_prot = '0;
  logic        i_rsp_ready = 1'b1;
  logic        o_cmd_ready, o_rsp_valid, o_rsp_write, o_rsp_timeout, o_busy;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_resp;
  int n_chk = 0, n_pass = 0;

  amba_axi4_lite_if amba();

  axil_cmd_master #(.CMD_DEPTH(4), .TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARSTn(ARSTn), .amba(amba),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb), .i_cmd_prot(i_cmd_prot),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_write(o_rsp_write),
    .o_rsp_data(o_rsp_data), .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout), .o_busy(o_busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Slave model: regs 0 and 1 are adder operands, reading 2 returns their sum,
  // addresses >= 0x100 answer DECERR (reads return 0xdeadbeef).
  logic [31:0] mem [256] = '{default: 32'h0};
  bit          aw_block = 0, ar_never = 0, b_block = 0;
  int          aw_stall = 0, aw_wait = 0;
  bit          aw_got, w_got, b_pend, r_pend, prev_awv;
  logic [31:0] aw_a, w_d, r_d, prev_awa;
  logic [3:0]  w_s;
  logic [2:0]  aw_p;
  logic [1:0]  b_rsp, r_rsp;
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_hs = 0, addr_chg = 0;
  logic [31:0] wlog [$];

  function automatic logic [31:0] rd_reg(input logic [31:0] a);
    return a >= 32'h100 ? 32'hdead_beef : a == 32'h2 ? mem[0] + mem[1] : mem[a[7:0]];
  endfunction

  always @(posedge ACLK) begin
    if (!ARSTn) begin
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; aw_wait = 0; prev_awv = 0;
    end else begin
      if (amba.awvalid) aw_cyc++;
      if (amba.wvalid) w_cyc++;
      if (amba.arvalid) ar_cyc++;
      if (amba.awvalid && prev_awv && amba.awaddr != prev_awa) addr_chg++;
      prev_awv = amba.awvalid && !amba.awready;
      prev_awa = amba.awaddr;
      if (amba.awvalid && amba.awready) begin
        aw_got = 1; aw_a = amba.awaddr; aw_p = amba.awprot; aw_wait = 0;
      end else if (amba.awvalid) aw_wait++;
      if (amba.wvalid && amba.wready) begin
        w_got = 1; w_d = amba.wdata; w_s = amba.wstrb;
      end
      if (amba.bvalid && amba.bready) begin
        b_pend = 0; b_hs++;
      end
      if (aw_got && w_got && !b_pend) begin
        if (aw_a < 32'h100)
          for (int b = 0; b < 4; b++) if (w_s[b]) mem[aw_a[7:0]][8*b +: 8] = w_d[8*b +: 8];
        b_rsp = aw_a >= 32'h100 ? 2'b11 : 2'b00;
        wlog.push_back(aw_a);
        b_pend = 1; aw_got = 0; w_got = 0;
      end
      if (amba.rvalid && amba.rready) r_pend = 0;
      if (amba.arvalid && amba.arready) begin
        r_pend = 1; r_d = rd_reg(amba.araddr); r_rsp = amba.araddr >= 32'h100 ? 2'b11 : 2'b00;
      end
    end
  end

  always @(negedge ACLK) begin
    amba.awready = !aw_block && aw_wait >= aw_stall;
    amba.wready  = 1'b1;
    amba.bvalid  = b_pend && !b_block;
    amba.bresp   = b_rsp;
    amba.arready = !ar_never;
    amba.rvalid  = r_pend;
    amba.rdata   = r_d;
    amba.rresp   = r_rsp;
  end

  // Scoreboard: expected responses queued at issue, compared when the DUT hands one over.
  typedef struct {logic w; logic [31:0] d; logic [1:0] r; logic t;} exp_t;
  exp_t exp_q [$];

  always @(negedge ACLK)
    if (ARSTn && o_rsp_valid && i_rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rsp_unexpected: got response write=%b data=%h with nothing expected", o_rsp_write, o_rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_write", o_rsp_write, e.w);
        chk("rsp_data", o_rsp_data, e.d);
        chk("rsp_resp", o_rsp_resp, e.r);
        chk("rsp_timeout", o_rsp_timeout, e.t);
      end
    end

  task automatic cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] ed,
                     input logic [1:0] er, input logic et = 1'b0, input logic [3:0] s = 4'hf, input logic ex = 1'b1);
    int n;
    n = 0;
    i_cmd_valid = 1; i_cmd_write = w; i_cmd_addr = a; i_cmd_data = d; i_cmd_strb = s; i_cmd_prot = 3'b010;
    while (!o_cmd_ready && n < 200) begin @(posedge ACLK); #1; n++; end
    if (n == 200) begin
      n_chk++;
      $display("FAIL cmd_accept: got no ready for addr %h, required acceptance within 200 cycles", a);
    end else if (ex) exp_q.push_back('{w, ed, er, et});
    @(posedge ACLK); #1;
    i_cmd_valid = 0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 500) begin @(posedge ACLK); #1; n++; end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    int a0, w0, b0, c0, l0, r0, n, bad;
    logic [31:0] d;
    logic [1:0]  r;
    logic        w;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_valids", {amba.awvalid, amba.wvalid, amba.arvalid, amba.bready, amba.rready, o_rsp_valid}, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cmd_ready", o_cmd_ready, 1);
    chk("rst_awaddr", amba.awaddr, 0);
    ARSTn = 1;
    @(posedge ACLK); #1;
    // 1: adder system plus DECERR and strobe patterns
    cmd(1, 32'h0, 32'h0000_aaaa, 0, 2'b00);
    cmd(1, 32'h1, 32'hbbbb_0000, 0, 2'b00);
    cmd(1, 32'h3, 32'h0000_0003, 0, 2'b00);
    cmd(0, 32'h2, 0, 32'hbbbb_aaaa, 2'b00);
    cmd(1, 32'h100, 32'h5, 0, 2'b11);
    cmd(0, 32'h100, 0, 32'hdead_beef, 2'b11);
    cmd(1, 32'h40, 32'h1122_3344, 0, 2'b00, 1'b0, 4'b0101);
    cmd(0, 32'h40, 0, 32'h0022_0044, 2'b00);
    drain("t1_drain");
    chk("t1_awprot", aw_p, 3'b010);
    // 2: AWREADY late, WREADY early
    aw_stall = 3;
    a0 = aw_cyc; w0 = w_cyc; b0 = b_hs; c0 = addr_chg;
    cmd(1, 32'h50, 32'h55, 0, 2'b00);
    drain("t2_drain");
    chk("t2_aw_cycles", aw_cyc - a0, 4);
    chk("t2_w_cycles", w_cyc - w0, 1);
    chk("t2_b_handshakes", b_hs - b0, 1);
    chk("t2_awaddr_changes", addr_chg - c0, 0);
    aw_stall = 0;
    // 3: back-pressure fills the FIFO, then drains in order
    aw_block = 1;
    l0 = wlog.size();
    for (int i = 0; i < 4; i++) cmd(1, 32'h60 + i, 32'h600 + i, 0, 2'b00);
    chk("t3_ready_after4", o_cmd_ready, 1);
    cmd(1, 32'h64, 32'h604, 0, 2'b00);
    chk("t3_ready_full", o_cmd_ready, 0);
    chk("t3_busy", o_busy, 1);
    aw_block = 0;
    drain("t3_drain");
    for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), wlog[l0 + i], 32'h60 + i);
    cmd(0, 32'h64, 0, 32'h604, 2'b00);
    drain("t3_readback");
    // 4: response held off
    i_rsp_ready = 0;
    cmd(0, 32'h61, 0, 32'h601, 2'b00);
    cmd(1, 32'h70, 32'h77, 0, 2'b00);
    n = 0;
    while (!o_rsp_valid && n < 100) begin @(posedge ACLK); #1; n++; end
    chk("t4_rsp_valid", o_rsp_valid, 1);
    d = o_rsp_data; r = o_rsp_resp; w = o_rsp_write;
    chk("t4_rsp_data", d, 32'h601);
    a0 = aw_cyc; r0 = ar_cyc; bad = 0;
    repeat (20) begin
      @(posedge ACLK); #1;
      if (o_rsp_data !== d || o_rsp_resp !== r || o_rsp_write !== w || !o_rsp_valid) bad++;
    end
    chk("t4_rsp_stable", bad, 0);
    chk("t4_no_issue", (aw_cyc - a0) + (ar_cyc - r0), 0);
    i_rsp_ready = 1;
    @(posedge ACLK);
    @(negedge ACLK);
    chk("t4_aw_idle", amba.awvalid, 0);
    @(negedge ACLK);
    chk("t4_aw_issue", amba.awvalid, 1);
    @(posedge ACLK); #1;
    drain("t4_drain");
    // 5: reset while waiting for B
    b_block = 1;
    cmd(1, 32'h80, 32'h88, 0, 2'b00, 1'b0, 4'hf, 1'b0);
    n = 0;
    while (!amba.bready && n < 50) begin @(posedge ACLK); #1; n++; end
    chk("t5_in_wr_resp", amba.bready, 1);
    #2 ARSTn = 0;
    #1;
    chk("t5_rst_valids", {amba.awvalid, amba.wvalid, amba.arvalid, amba.bready, amba.rready, o_rsp_valid}, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_awaddr", amba.awaddr, 0);
    b_block = 0;
    repeat (2) @(posedge ACLK);
    #1 ARSTn = 1;
    @(posedge ACLK); #1;
    cmd(1, 32'h81, 32'h99, 0, 2'b00);
    cmd(0, 32'h81, 0, 32'h99, 2'b00);
    drain("t5_drain");
`ifdef AXIL_TIMEOUT_EN
    // 6: slave never accepts AR
    ar_never = 1;
    r0 = ar_cyc;
    cmd(0, 32'h10, 0, 0, 2'b10, 1'b1);
    cmd(1, 32'h90, 32'h9, 0, 2'b00);
    drain("t6_drain");
    chk("t6_ar_cycles", ar_cyc - r0, 9);
    ar_never = 0;
    cmd(0, 32'h90, 0, 32'h9, 2'b00);
    drain("t6_readback");
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
